execute_pipe: RTL and testbench

- Parametrised, registered execute stage; successor to the single-cycle combinational execute block.
- Selects operand B (register or immediate) and performs ALU/shift ops in one cycle.
- Performs an iterative shift-add multiply over WIDTH cycles.
- Sits between decode and memory, with valid/ready handshakes on both sides so the multiply can stall the pipeline.

---
 rtl/exec_pkg.sv | 30 +++
 rtl/exec_mul_iter.sv | 54 +++++
 rtl/execute_pipe.sv | 176 +++++++++++++++++
 tb/tb_execute_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared opcodes, state encoding and result-flag bundle for the execute stage.
package exec_pkg;

    localparam int DEF_WIDTH = 16;

    localparam logic [3:0] OP_ROL   = 4'd0;
    localparam logic [3:0] OP_SLL   = 4'd1;
    localparam logic [3:0] OP_ROR   = 4'd2;
    localparam logic [3:0] OP_SRL   = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_ANDN  = 4'd7;
    localparam logic [3:0] OP_AND   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_PASSB = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;

    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
        logic cf;
        logic err;
    } flags_t;

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle, WIDTH cycles.
module exec_mul_iter
    import exec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic               busy;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
            end else begin
                if (mplier[0])
                    acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end

    // done is seen for one cycle once all WIDTH bits have been consumed
    assign done    = busy && (cnt == CNT_W'(WIDTH));
    assign product = acc;

endmodule

// File: rtl/execute_pipe.sv
// Registered execute stage with valid/ready on both sides.
// EXEC_PIPE_MUL_EN adds the iterative MUL opcode; otherwise opcode 12 is illegal.
module execute_pipe
    import exec_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] read1Data,
    input  logic [WIDTH-1:0] read2Data,
    input  logic [WIDTH-1:0] immExt,
    input  logic             aluSrc,
    input  logic [3:0]       aluOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluOut,
    output logic [WIDTH-1:0] aluOutHi,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             cf,
    output logic             err
);

    state_t             state, state_nxt;
    logic               accept, is_mul, mul_done;
    logic [WIDTH-1:0]   b_sel, res, ld_lo, lo_q;
    logic               res_cf, res_of, res_err;
    logic [SHAMT_W-1:0] sh;
    logic [2*WIDTH-1:0] rol2, ror2;
    logic [WIDTH:0]     sum, diff;
    flags_t             ld_fl, fl_q;

    assign b_sel  = aluSrc ? immExt : read2Data;
    assign accept = in_valid && in_ready;

`ifdef EXEC_PIPE_MUL_EN
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   hi_q;

    assign is_mul = (aluOp == OP_MUL);

    exec_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (read1Data),
        .b       (b_sel),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            hi_q <= '0;
        else if (mul_done)
            hi_q <= product[2*WIDTH-1:WIDTH];
        else if (accept)
            hi_q <= '0;
    end
    assign aluOutHi = hi_q;
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign aluOutHi = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
`ifdef EXEC_PIPE_MUL_EN
        case (state)
            IDLE:    if (accept && is_mul) state_nxt = MUL;
            MUL:     if (mul_done)         state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`else
        state_nxt = IDLE;
`endif
    end

    always_comb begin
        in_ready = (state == IDLE) && (!out_valid || out_ready);
    end

    // Both halves of the doubled operand are useful: high=ROL/SRL, low=SLL/ROR
    always_comb begin
        sh      = b_sel[SHAMT_W-1:0];
        rol2    = {read1Data, read1Data} << sh;
        ror2    = {read1Data, read1Data} >> sh;
        sum     = {1'b0, read1Data} + {1'b0, b_sel};
        diff    = {1'b0, read1Data} - {1'b0, b_sel};
        res     = '0;
        res_cf  = 1'b0;
        res_of  = 1'b0;
        res_err = 1'b0;
        case (aluOp)
            OP_ROL:   res = rol2[2*WIDTH-1:WIDTH];
            OP_SLL:   res = rol2[WIDTH-1:0];
            OP_ROR:   res = ror2[WIDTH-1:0];
            OP_SRL:   res = ror2[2*WIDTH-1:WIDTH];
            OP_SRA:   res = $unsigned($signed(read1Data) >>> sh);
            OP_ADD: begin
                res    = sum[WIDTH-1:0];
                res_cf = sum[WIDTH];
                res_of = (read1Data[WIDTH-1] == b_sel[WIDTH-1]) &&
                         (sum[WIDTH-1] != read1Data[WIDTH-1]);
            end
            OP_SUB: begin
                res    = diff[WIDTH-1:0];
                res_cf = diff[WIDTH];
                res_of = (read1Data[WIDTH-1] != b_sel[WIDTH-1]) &&
                         (diff[WIDTH-1] != read1Data[WIDTH-1]);
            end
            OP_XOR:   res = read1Data ^ b_sel;
            OP_ANDN:  res = read1Data & ~b_sel;
            OP_AND:   res = read1Data & b_sel;
            OP_OR:    res = read1Data | b_sel;
            OP_PASSB: res = b_sel;
`ifdef EXEC_PIPE_MUL_EN
            OP_MUL:   res = '0;
`endif
            default:  res_err = 1'b1;
        endcase
    end

    always_comb begin
        ld_lo      = res;
        ld_fl.zf   = (res == '0);
        ld_fl.sf   = res[WIDTH-1];
        ld_fl.of   = res_of;
        ld_fl.cf   = res_cf;
        ld_fl.err  = res_err;
`ifdef EXEC_PIPE_MUL_EN
        if (mul_done) begin
            ld_lo     = product[WIDTH-1:0];
            ld_fl.zf  = (product[WIDTH-1:0] == '0);
            ld_fl.sf  = product[WIDTH-1];
            ld_fl.of  = 1'b0;
            ld_fl.cf  = |product[2*WIDTH-1:WIDTH];
            ld_fl.err = 1'b0;
        end
`endif
    end

    // A held result blocks acceptance through in_ready, so loads never overwrite it
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            lo_q      <= '0;
            fl_q      <= '0;
        end else if (mul_done || (accept && !is_mul)) begin
            out_valid <= 1'b1;
            lo_q      <= ld_lo;
            fl_q      <= ld_fl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign aluOut = lo_q;
    assign zf     = fl_q.zf;
    assign sf     = fl_q.sf;
    assign of     = fl_q.of;
    assign cf     = fl_q.cf;
    assign err    = fl_q.err;

endmodule

// File: tb/tb_execute_pipe.sv
// Scoreboard bench for execute_pipe (WIDTH=16); MUL expectations follow EXEC_PIPE_MUL_EN.
module tb_execute_pipe;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, aluSrc, out_valid, out_ready;
    logic [15:0] read1Data, read2Data, immExt, aluOut, aluOutHi;
    logic [3:0]  aluOp;
    logic        zf, sf, of, cf, err;

    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        zf, sf, of, cf, err;
    } resp_t;

    resp_t sb[$];
    int    pop_cyc[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;

    execute_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .read1Data(read1Data), .read2Data(read2Data), .immExt(immExt),
        .aluSrc(aluSrc), .aluOp(aluOp), .out_valid(out_valid),
        .out_ready(out_ready), .aluOut(aluOut), .aluOutHi(aluOutHi),
        .zf(zf), .sf(sf), .of(of), .cf(cf), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each consumed result is checked against the oldest expectation
    always @(negedge clk) begin : mon
        resp_t act, e;
        if (rst && out_valid && out_ready) begin
            act = '{aluOut, aluOutHi, zf, sf, of, cf, err};
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL result: unexpected lo=%h hi=%h flags(zsocE)=%b%b%b%b%b",
                         act.lo, act.hi, act.zf, act.sf, act.of, act.cf, act.err);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin
                    fails++;
                    $display("FAIL result: got lo=%h hi=%h flags(zsocE)=%b%b%b%b%b, expected lo=%h hi=%h flags(zsocE)=%b%b%b%b%b",
                             act.lo, act.hi, act.zf, act.sf, act.of, act.cf, act.err,
                             e.lo, e.hi, e.zf, e.sf, e.of, e.cf, e.err);
                end
            end
            pop_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_r(input logic [15:0] lo, input logic [15:0] hi,
                            input logic z, input logic s, input logic o,
                            input logic c, input logic e);
        sb.push_back('{lo, hi, z, s, o, c, e});
    endtask

    // Called at posedge+1; returns at posedge+1 after the op is accepted
    task automatic send(input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] r2, input logic [15:0] imm, input logic src);
        int n;
        n = 0;
        in_valid = 1'b1; aluOp = op; read1Data = a; read2Data = r2;
        immExt = imm; aluSrc = src;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                tests++; fails++;
                $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_in_ready"}, in_ready, 1);
        chk({name, "_aluOut"}, aluOut, 0);
        chk({name, "_aluOutHi"}, aluOutHi, 0);
        chk({name, "_flags"}, {zf, sf, of, cf, err}, 0);
    endtask

    initial begin
        int n, d;
        rst = 1'b0; in_valid = 1'b0; aluOp = '0; read1Data = '0; read2Data = '0;
        immExt = '0; aluSrc = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;

        // Reset held two cycles while a MUL (or its illegal result) is in flight
        send(OP_MUL, 16'h1234, 16'h0100, 16'h0000, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_zero("mid_mul_reset");
        @(posedge clk); #1;

        out_ready = 1'b1;
        expect_r(16'h8000, 0, 0, 1, 1, 0, 0); send(OP_ADD, 16'h7FFF, 16'h0001, 16'h0000, 1'b0);
        expect_r(16'hFFFE, 0, 0, 1, 0, 1, 0); send(OP_SUB, 16'h0003, 16'h0000, 16'h0005, 1'b1);
        expect_r(16'h8000, 0, 0, 1, 0, 0, 0); send(OP_XOR, 16'h8001, 16'h0001, 16'h0000, 1'b0);
        expect_r(16'hC000, 0, 0, 1, 0, 0, 0); send(OP_ROR, 16'h8001, 16'h0001, 16'h0000, 1'b0);
        drain();
        if (pop_cyc.size() >= 2) begin
            d = pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2];
            chk("back_to_back_gap", d, 1);
        end else begin
            tests++; fails++;
            $display("FAIL back_to_back_count: got %0d pops required >=2", pop_cyc.size());
        end

        expect_r(16'hA5C3, 0, 0, 1, 0, 0, 0); send(OP_ROL,   16'hA5C3, 16'h0010, 16'h0000, 1'b0);
        expect_r(16'h0000, 0, 1, 0, 0, 0, 0); send(OP_SUB,   16'h1234, 16'h1234, 16'h0000, 1'b0);
        expect_r(16'hF800, 0, 0, 1, 0, 0, 0); send(OP_SRA,   16'h8000, 16'h0004, 16'h0000, 1'b0);
        expect_r(16'h8000, 0, 0, 1, 0, 0, 0); send(OP_SLL,   16'h0001, 16'h000F, 16'h0000, 1'b0);
        expect_r(16'h0001, 0, 0, 0, 0, 0, 0); send(OP_SRL,   16'h8000, 16'h000F, 16'h0000, 1'b0);
        expect_r(16'h0000, 0, 1, 0, 0, 1, 0); send(OP_ADD,   16'hFFFF, 16'h0001, 16'h0000, 1'b0);
        expect_r(16'h00F0, 0, 0, 0, 0, 0, 0); send(OP_ANDN,  16'hF0F0, 16'hFF00, 16'h0000, 1'b0);
        expect_r(16'hF000, 0, 0, 1, 0, 0, 0); send(OP_AND,   16'hF0F0, 16'hFF00, 16'h0000, 1'b0);
        expect_r(16'hFFF0, 0, 0, 1, 0, 0, 0); send(OP_OR,    16'hF0F0, 16'hFF00, 16'h0000, 1'b0);
        expect_r(16'h00AB, 0, 0, 0, 0, 0, 0); send(OP_PASSB, 16'h1111, 16'hFFFF, 16'h00AB, 1'b1);
        expect_r(16'h0000, 0, 1, 0, 0, 0, 1); send(4'd14,    16'h1234, 16'h5678, 16'h0000, 1'b0);
        @(negedge clk);
        chk("illegal_latency1", {out_valid, err}, 2'b11);
        @(posedge clk); #1;
        drain();

        // MUL with downstream stalled: stage must stay closed, then hold the result
        out_ready = 1'b0;
`ifdef EXEC_PIPE_MUL_EN
        expect_r(16'h3400, 16'h0012, 0, 0, 0, 1, 0);
`else
        expect_r(16'h0000, 16'h0000, 1, 0, 0, 0, 1);
`endif
        send(OP_MUL, 16'h1234, 16'h0100, 16'h0000, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("mul_in_ready_low", in_ready, 0);
            if (i == 0) begin
`ifdef EXEC_PIPE_MUL_EN
                chk("mul_busy_no_valid", out_valid, 0);
`else
                chk("op12_err_latency1", {out_valid, err}, 2'b11);
`endif
            end
        end
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("mul_result_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
`ifdef EXEC_PIPE_MUL_EN
            chk("mul_hold", {out_valid, in_ready, aluOut, aluOutHi, cf}, {1'b1, 1'b0, 16'h3400, 16'h0012, 1'b1});
`else
            chk("op12_hold", {out_valid, in_ready, aluOut, err}, {1'b1, 1'b0, 16'h0000, 1'b1});
`endif
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
